mm_seq_ctrl: RTL and testbench
==============================

# mm_seq_ctrl

Sequencer between the AXI-Lite control register block and the matrix compute core. On a start pulse it latches the M/N/K configuration, walks output element (row, col) and reduction index k in row-major order, and issues one MAC command per (row, col, k) to the core over a valid/ready handshake. It then counts completed output elements and raises a done pulse once all M×N results are back. Busy, done and error status feed the status register.

## Interface
- DIM_W, 8, width of each dimension and loop counter (M, N, K up to 2^DIM_W−1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle start pulse from ctrl register write
- abort  in  1  level or pulse; cancels a run in progress
- cfg_m  in  DIM_W  output rows M
- cfg_n  in  DIM_W  output columns N
- cfg_k  in  DIM_W  reduction length K
- cmd_valid  out  1  MAC command valid
- cmd_ready  in  1  core accepts command
- cmd_row  out  DIM_W  row index i
- cmd_col  out  DIM_W  column index j
- cmd_kidx  out  DIM_W  reduction index k
- cmd_first  out  1  k == 0; core clears its accumulator
- cmd_last  out  1  k == K−1; core writes back element after this MAC
- res_valid  in  1  core reports one output element completed
- res_ready  out  1  sequencer accepts result report
- busy  out  1  run in progress (ISSUE or DRAIN)
- done  out  1  one-cycle pulse at successful completion
- err_cfg  out  1  sticky; last start had a zero dimension
- aborted  out  1  sticky; last run was aborted

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and all cfg nonzero → latch M/N/K, zero i/j/k and res_cnt, clear err_cfg and aborted, go to ISSUE.
  - start=1 with any cfg == 0 → set err_cfg, clear aborted, stay in IDLE; no commands issued.
- ISSUE:
  - cmd_valid=1; cmd_* are driven from registered counters and stay stable until the command fires (cmd_valid & cmd_ready).
  - On each fire: k increments. At k == K−1, k wraps to 0 and j increments. At j == N−1, j wraps to 0 and i increments.
  - Fire with i == M−1, j == N−1, k == K−1 → go to DRAIN.
- DRAIN: cmd_valid=0. When a result fire brings res_cnt to M·N, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Result counting:
  - res_ready=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
  - Each res_valid & res_ready increments res_cnt, which is 2·DIM_W bits wide. Total commands = M·N·K; total results = M·N.
  - Results that fire during ISSUE are counted, including a result that fires in the same cycle as the last command.
- start while busy or in DONE: ignored, with no effect on latched config or flags.
- abort in ISSUE, DRAIN or DONE → IDLE on the next edge; set aborted; no done pulse; counters cleared. cmd_valid may drop without a fire, and the core flushes on abort. abort in IDLE has no effect. abort has priority over start in the same cycle.
- rst mid-run: immediate return to IDLE; all state cleared.

## Timing
- Reset values: cmd_valid=0, cmd_row/col/kidx=0, cmd_first=0, cmd_last=0, res_ready=0, busy=0, done=0, err_cfg=0, aborted=0; state IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational path from cmd_ready or res_valid to any output.
- Start accepted at edge t → busy=1 and cmd_valid=1 from cycle t+1.
- With cmd_ready held high, one command fires per cycle. The last command fires at cycle t+M·N·K.
- The result fire that completes res_cnt at edge u → done=1 in cycle u+1, and busy=0 in that same cycle. IDLE from u+2. A new start is accepted from the cycle state is IDLE.
- err_cfg is set on the edge after the rejected start.

## Test plan
- M=2, N=2, K=3, cmd_ready=1, core returns res_valid 2 cycles after each cmd_last. Required:
  - 12 commands in order (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2).
  - cmd_first on k=0 only, cmd_last on k=2 only.
  - done pulse once, 1 cycle after the 4th result.
- Same config with cmd_ready toggling pseudo-randomly → cmd_* stable while cmd_valid=1 and cmd_ready=0; identical command sequence; single done.
- start with cfg_k=0 → err_cfg=1 next cycle, busy stays 0, zero commands. Then a valid start (1,1,1) → err_cfg clears, one command, done.
- abort asserted after 5 of 12 commands → IDLE next cycle, cmd_valid=0, aborted=1, no done. A following start runs the full 12 commands.
- start pulsed again mid-run with different cfg → ignored; original M·N·K command count is issued and done pulses once.
- M=N=K=1 with res_valid in the same cycle as the sole command fire → DRAIN is skipped in effect; done in the second cycle after the fire. Extra res_valid in IDLE is not accepted (res_ready=0).

Source files
------------

// File: rtl/mm_seq_if.sv
// mm_seq_if
// Command/result handshake between the matrix sequencer and the compute core.
//   cmd_valid/cmd_ready : one MAC command per handshake
//   cmd_row/col/kidx    : output element (row, col) and reduction index
//   cmd_first/cmd_last  : first / last MAC of an output element
//   res_valid/res_ready : one completed output element per handshake
// master = sequencer side, slave = core side.
interface mm_seq_if #(
  parameter int DIM_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_row;
  logic [DIM_W-1:0] cmd_col;
  logic [DIM_W-1:0] cmd_kidx;
  logic             cmd_first;
  logic             cmd_last;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output cmd_valid, cmd_row, cmd_col, cmd_kidx, cmd_first, cmd_last, res_ready,
    input  cmd_ready, res_valid
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_col, cmd_kidx, cmd_first, cmd_last, res_ready,
    output cmd_ready, res_valid
  );
endinterface

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl
// Walks (row, col, k) in row-major order for an M x N x K matrix product,
// issues one MAC command per step, then counts M*N completed output elements
// and pulses done.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_i, abort_i    : run start pulse, run cancel
//   cfg_m_i/n_i/k_i     : dimensions, latched on an accepted start
//   bus (master)        : command and result handshakes to the core
//   busy_o, done_o      : run in progress, one-cycle completion pulse
//   err_cfg_o           : sticky, last start had a zero dimension
//   aborted_o           : sticky, last run was aborted
module mm_seq_ctrl #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] cfg_m_i,
  input  logic [DIM_W-1:0] cfg_n_i,
  input  logic [DIM_W-1:0] cfg_k_i,
  mm_seq_if.master         bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_cfg_o,
  output logic             aborted_o
);
  localparam int CNT_W = 2 * DIM_W;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIM_W-1:0] i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d, total_q, total_d;
  logic             err_q, err_d, abt_q, abt_d;

  logic             cmd_fire, res_fire, last_k, last_j, last_i, cfg_ok;
  logic [CNT_W-1:0] res_cnt_nxt;

  assign last_k      = (kk_q == k_q - ONE);
  assign last_j      = (j_q == n_q - ONE);
  assign last_i      = (i_q == m_q - ONE);
  assign cfg_ok      = (cfg_m_i != '0) && (cfg_n_i != '0) && (cfg_k_i != '0);
  assign cmd_fire    = (state_q == S_ISSUE) && bus.cmd_ready;
  assign res_fire    = bus.res_ready && bus.res_valid;
  assign res_cnt_nxt = res_cnt_q + CNT_W'(res_fire);

  // All outputs decode registered state only, so cmd_ready/res_valid never
  // reach an output combinationally.
  assign bus.cmd_valid = (state_q == S_ISSUE);
  assign bus.cmd_row   = i_q;
  assign bus.cmd_col   = j_q;
  assign bus.cmd_kidx  = kk_q;
  assign bus.cmd_first = (state_q == S_ISSUE) && (kk_q == '0);
  assign bus.cmd_last  = (state_q == S_ISSUE) && last_k;
  assign bus.res_ready = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o        = (state_q == S_DONE);
  assign err_cfg_o     = err_q;
  assign aborted_o     = abt_q;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    kk_d      = kk_q;
    res_cnt_d = res_cnt_q;
    total_d   = total_q;
    err_d     = err_q;
    abt_d     = abt_q;

    unique case (state_q)
      S_IDLE: begin
        // abort outranks a coincident start
        if (start_i && !abort_i) begin
          abt_d = 1'b0;
          if (cfg_ok) begin
            m_d       = cfg_m_i;
            n_d       = cfg_n_i;
            k_d       = cfg_k_i;
            total_d   = CNT_W'(cfg_m_i) * CNT_W'(cfg_n_i);
            i_d       = '0;
            j_d       = '0;
            kk_d      = '0;
            res_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // results arriving while commands are still going out count too
        res_cnt_d = res_cnt_nxt;
        if (cmd_fire) begin
          if (!last_k) begin
            kk_d = kk_q + ONE;
          end else begin
            kk_d = '0;
            if (!last_j) begin
              j_d = j_q + ONE;
            end else begin
              j_d = '0;
              if (!last_i) begin
                i_d = i_q + ONE;
              end else begin
                i_d     = '0;
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        // >= also covers a count already completed during ISSUE
        res_cnt_d = res_cnt_nxt;
        if (res_cnt_nxt >= total_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      abt_d     = 1'b1;
      i_d       = '0;
      j_d       = '0;
      kk_d      = '0;
      res_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      kk_q      <= '0;
      res_cnt_q <= '0;
      total_q   <= '0;
      err_q     <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      n_q       <= n_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      kk_q      <= kk_d;
      res_cnt_q <= res_cnt_d;
      total_q   <= total_d;
      err_q     <= err_d;
      abt_q     <= abt_d;
    end
  end
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl: the stimulus side pushes the expected
// command stream (plain nested loops over M/N/K) into a queue; a negedge
// monitor pops and compares every command fire, checks command stability
// under back-pressure, and predicts the done cycle from result arrivals.
module tb_mm_seq_ctrl;
  localparam int DIM_W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] k;
    logic       f;
    logic       l;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIM_W-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic             busy, done, err_cfg, aborted;

  mm_seq_if #(.DIM_W(DIM_W)) bus ();

  mm_seq_ctrl #(.DIM_W(DIM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .abort_i   (abort),
    .cfg_m_i   (cfg_m),
    .cfg_n_i   (cfg_n),
    .cfg_k_i   (cfg_k),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done),
    .err_cfg_o (err_cfg),
    .aborted_o (aborted)
  );

  always #5 clk = ~clk;

  int   checks = 0, passes = 0;
  int   cyc = 0;
  cmd_t exp_q[$];
  int   pend_q[$];
  int   exp_done_q[$];
  int   exp_mn = 0, res_seen = 0, fires = 0, last_fire = -10, done_cnt = 0, acc_cyc = 0;
  bit   rand_ready = 0, rv_same = 0, extra_rv = 0;
  bit   have_prev = 0;
  cmd_t prev_cmd, cur_cmd, exp_cmd;
  logic rv;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // core model: ready pattern and result reports
  initial begin
    bus.cmd_ready = 1'b1;
    bus.res_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rv = extra_rv || (rv_same && bus.cmd_valid && bus.cmd_last);
      if (pend_q.size() > 0 && pend_q[0] == cyc) begin
        rv = 1'b1;
        void'(pend_q.pop_front());
      end
      bus.res_valid = rv;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid) begin
        cur_cmd = {bus.cmd_row, bus.cmd_col, bus.cmd_kidx, bus.cmd_first, bus.cmd_last};
        if (have_prev) chk("cmd_stable", cur_cmd, prev_cmd);
        if (bus.cmd_ready) begin
          fires++;
          last_fire = cyc;
          chk("cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_cmd = exp_q.pop_front();
            chk("cmd_value", cur_cmd, exp_cmd);
          end
          if (bus.cmd_last && !rv_same) pend_q.push_back(cyc + 2);
          have_prev = 0;
        end else begin
          have_prev = 1;
          prev_cmd  = cur_cmd;
        end
      end else begin
        have_prev = 0;
      end
      if (bus.res_valid && bus.res_ready) begin
        res_seen++;
        if (res_seen == exp_mn)
          exp_done_q.push_back((cyc + 1 > last_fire + 2) ? cyc + 1 : last_fire + 2);
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) chk("done_unexpected", cyc, -1);
        else chk("done_cycle", cyc, exp_done_q.pop_front());
      end
    end
  end

  task automatic start_run(input int m, input int n, input int k);
    cmd_t e;
    bit   ok;
    ok = (m != 0) && (n != 0) && (k != 0);
    @(posedge clk);
    #1;
    cfg_m = DIM_W'(m);
    cfg_n = DIM_W'(n);
    cfg_k = DIM_W'(k);
    start = 1'b1;
    if (ok) begin
      exp_q.delete();
      pend_q.delete();
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++)
          for (int kk = 0; kk < k; kk++) begin
            e.r = 8'(i);
            e.c = 8'(j);
            e.k = 8'(kk);
            e.f = (kk == 0);
            e.l = (kk == k - 1);
            exp_q.push_back(e);
          end
      exp_mn   = m * n;
      res_seen = 0;
      fires    = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (ok) begin
      chk("start_status", {busy, bus.cmd_valid, err_cfg, aborted}, 4'b1100);
      acc_cyc = cyc;
    end else begin
      chk("cfg_err_status", {busy, bus.cmd_valid, err_cfg, aborted}, 4'b0010);
    end
  endtask

  task automatic wait_done(input int budget, input int exp_cmds);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("cmd_count", fires, exp_cmds);
    chk("post_done", {busy, done, bus.cmd_valid, bus.res_ready}, 4'b0000);
  endtask

  initial begin
    int n;
    int m, nn, k;
    cfg_m = 8'd3;
    cfg_n = 8'd3;
    cfg_k = 8'd3;
    repeat (3) @(negedge clk);
    chk("reset_vals", {bus.cmd_valid, bus.cmd_row, bus.cmd_col, bus.cmd_kidx, bus.cmd_first,
                       bus.cmd_last, bus.res_ready, busy, done, err_cfg, aborted}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // basic run, cmd_ready high
    start_run(2, 2, 3);
    wait_done(200, 12);
    chk("last_fire_time", last_fire, acc_cyc + 11);

    // back-pressure
    rand_ready = 1;
    start_run(2, 2, 3);
    wait_done(500, 12);

    // zero dimension rejected, then a minimal run
    rand_ready = 0;
    start_run(2, 2, 0);
    repeat (4) @(negedge clk);
    chk("cfg_err_idle", {busy, err_cfg, 8'(fires)}, {2'b01, 8'd12});
    start_run(1, 1, 1);
    chk("err_cleared", err_cfg, 0);
    wait_done(50, 1);

    // abort after five commands
    start_run(2, 2, 3);
    n = 0;
    while (fires < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach5", fires >= 5, 1);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    pend_q.delete();
    exp_mn = 0;
    @(negedge clk);
    chk("abort_state", {busy, bus.cmd_valid, aborted, done}, 4'b0010);
    repeat (6) @(negedge clk);
    chk("abort_stays_idle", {busy, aborted}, 2'b01);
    start_run(2, 2, 3);
    wait_done(200, 12);

    // start mid-run is ignored
    rand_ready = 1;
    start_run(2, 2, 3);
    repeat (4) @(posedge clk);
    #1;
    cfg_m = 8'd1;
    cfg_n = 8'd1;
    cfg_k = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(500, 12);

    // randomized configurations with back-pressure
    for (int r = 0; r < 4; r++) begin
      m  = $urandom_range(1, 3);
      nn = $urandom_range(1, 3);
      k  = $urandom_range(1, 4);
      start_run(m, nn, k);
      wait_done(1000, m * nn * k);
    end
    rand_ready = 0;

    // result in the same cycle as the only command
    rv_same = 1;
    start_run(1, 1, 1);
    wait_done(50, 1);
    rv_same = 0;

    // result report while idle is not accepted
    @(posedge clk);
    #1;
    extra_rv = 1;
    n = res_seen;
    repeat (2) @(negedge clk);
    chk("idle_res_ready", bus.res_ready, 0);
    chk("idle_res_uncounted", res_seen, n);
    extra_rv = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: cycle %0d, required completion before limit", cyc);
    $fatal(1, "timeout");
  end
endmodule
